// File: rtl/des_key_scheduler_pkg.sv
// Shared tables, rotate helpers and FSM state type for the sequential DES/3DES key scheduler.
// Table entries use DES numbering: bit 1 is the MSB of the source vector.
package des_key_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } state_e;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} :
               (n == 2'd1) ? {x[26:0], x[27]} : x;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} :
               (n == 2'd1) ? {x[0], x[27:1]} : x;
    endfunction

    // Parity bits (8, 16, ..., 64) are simply never selected.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1_TAB[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_key_scheduler_if.sv
// Key request and subkey stream signals between the key register file, the scheduler and the round core.
interface des_key_scheduler_if #(
    parameter int NUM_KEYS = 3
);
    logic                    key_valid;
    logic                    key_ready;
    logic [64*NUM_KEYS-1:0]  key;
    logic                    decrypt;
    logic                    sk_valid;
    logic                    sk_ready;
    logic [47:0]             subkey;
    logic [3:0]              sk_round;
    logic [1:0]              sk_stage;
    logic                    sk_decrypt;
    logic                    sk_last;
    logic                    busy;

    modport slave (
        input  key_valid, key, decrypt, sk_ready,
        output key_ready, sk_valid, subkey, sk_round, sk_stage, sk_decrypt, sk_last, busy
    );

    modport master (
        output key_valid, key, decrypt, sk_ready,
        input  key_ready, sk_valid, subkey, sk_round, sk_stage, sk_decrypt, sk_last, busy
    );
endinterface

// File: rtl/des_key_scheduler_pc2.sv
// PC2 compression: selects 48 of the 56 C/D bits to form one round subkey.
module des_pc2 (
    input  logic [55:0] cd_i,
    output logic [47:0] subkey_o
);
    import des_key_scheduler_pkg::*;

    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
        assign subkey_o[47-gi] = cd_i[56-PC2_TAB[gi]];
    end
endmodule

// File: rtl/des_key_scheduler.sv
// Streams the 16 round subkeys of each DES stage of a single-DES or EDE 3DES request,
// one per handshake, walking C/D forward for encrypt stages and backward for decrypt stages.
module des_key_scheduler #(
    parameter int NUM_KEYS = 3
) (
    input  logic              clk,
    input  logic              reset,
    des_key_scheduler_if.slave kif
);
    import des_key_scheduler_pkg::*;

    localparam int         NUM_STAGES = (NUM_KEYS == 1) ? 1 : 3;
    localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

    state_e                 state_q;
    logic [64*NUM_KEYS-1:0] key_q;
    logic                   decrypt_q;
    logic [55:0]            cd_q;
    logic [3:0]             round_q;
    logic [1:0]             stage_q;
    logic                   dir_q;
    logic                   sk_valid_q;
    logic                   sk_last_q;
    logic                   key_ready_q;
    logic                   busy_q;

    logic [63:0]            keys [3];
    logic [1:0]             key_idx;
    logic                   stage_dir;
    logic [55:0]            stage_pc1;
    logic [47:0]            subkey;

    // Slot 2 (K3) wraps onto K1 for two-key 3DES; single DES maps every slot to K1.
    for (genvar gi = 0; gi < 3; gi++) begin : g_keys
        assign keys[gi] = key_q[64*(gi % NUM_KEYS) +: 64];
    end

    // Encrypt plan K1/K2/K3 as E/D/E, decrypt plan K3/K2/K1 as D/E/D.
    always_comb begin
        key_idx   = decrypt_q ? (2'd2 - stage_q) : stage_q;
        stage_dir = decrypt_q ^ (stage_q == 2'd1);
    end

    assign stage_pc1 = pc1(keys[key_idx]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            decrypt_q   <= 1'b0;
            cd_q        <= '0;
            round_q     <= '0;
            stage_q     <= '0;
            dir_q       <= 1'b0;
            sk_valid_q  <= 1'b0;
            sk_last_q   <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (kif.key_valid && key_ready_q) begin
                        key_q       <= kif.key;
                        decrypt_q   <= kif.decrypt;
                        stage_q     <= '0;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    // PC1(K) is C16/D16 as well as C0/D0, so decrypt starts unrotated.
                    cd_q       <= stage_dir ? stage_pc1
                                            : {rotl28(stage_pc1[55:28], SHIFT_TAB[0]),
                                               rotl28(stage_pc1[27:0],  SHIFT_TAB[0])};
                    dir_q      <= stage_dir;
                    round_q    <= '0;
                    sk_valid_q <= 1'b1;
                    sk_last_q  <= 1'b0;
                    state_q    <= EMIT;
                end
                EMIT: begin
                    if (kif.sk_ready) begin
                        if (dir_q) begin
                            cd_q <= {rotr28(cd_q[55:28], SHIFT_TAB[4'd15 - round_q]),
                                     rotr28(cd_q[27:0],  SHIFT_TAB[4'd15 - round_q])};
                        end else begin
                            cd_q <= {rotl28(cd_q[55:28], SHIFT_TAB[round_q + 4'd1]),
                                     rotl28(cd_q[27:0],  SHIFT_TAB[round_q + 4'd1])};
                        end
                        round_q   <= round_q + 4'd1;
                        sk_last_q <= (round_q == 4'd14) && (stage_q == LAST_STAGE);
                        if (round_q == 4'd15) begin
                            sk_valid_q <= 1'b0;
                            sk_last_q  <= 1'b0;
                            if (stage_q != LAST_STAGE) begin
                                stage_q <= stage_q + 2'd1;
                                state_q <= LOAD;
                            end else begin
                                key_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd_i     (cd_q),
        .subkey_o (subkey)
    );

    assign kif.key_ready  = key_ready_q;
    assign kif.busy       = busy_q;
    assign kif.sk_valid   = sk_valid_q;
    assign kif.subkey     = subkey;
    assign kif.sk_round   = round_q;
    assign kif.sk_stage   = stage_q;
    assign kif.sk_decrypt = dir_q;
    assign kif.sk_last    = sk_last_q;
endmodule
